// File: rtl/budget_accum_if.sv
// Beat channel into budget_accum.
// Handshake: a beat transfers on a posedge where in_valid && in_ready are both
// high. The master holds in_chan/in_data stable while in_valid is high and
// in_ready is low. in_ready is a registered function of the slave's state and
// never depends combinationally on in_valid.
interface budget_accum_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_chan;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_chan, output in_data, input in_ready);
    modport slave  (input in_valid, input in_chan, input in_data, output in_ready);
endinterface

// File: rtl/budget_accum.sv
// Multi-channel budget accumulator. Each channel sums accepted beats against
// MAX_COUNT; a beat that would overrun the remaining margin either restarts the
// channel (MODE 0) or pins it at the budget (MODE 1). clr_all launches a sweep
// that clears one channel per cycle while input beats are held off.
module budget_accum #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 2,
    parameter int MAX_COUNT = 111,
    parameter int MODE      = 0,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    budget_accum_if.slave             in_if,
    input  logic                      clr_all,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS*WIDTH-1:0] margin,
    output logic [CHANNELS-1:0]       hit,
    output logic                      ovf_valid,
    output logic [CW-1:0]             ovf_chan,
    output logic                      sweep_busy
);

    localparam logic [0:0]       ST_RUN   = 1'b0;
    localparam logic [0:0]       ST_SWEEP = 1'b1;
    localparam logic [WIDTH-1:0] MAX_W    = MAX_COUNT[WIDTH-1:0];
    localparam logic [CW-1:0]    LAST_CH  = CW'(CHANNELS - 1);
    // One extra bit so the range check also works when CHANNELS == 2**CW.
    localparam logic [CW:0]      CH_LIM   = CHANNELS[CW:0];

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] count_q  [CHANNELS];
    logic [WIDTH-1:0] count_d  [CHANNELS];
    logic [WIDTH-1:0] margin_q [CHANNELS];
    logic [WIDTH-1:0] margin_d [CHANNELS];
    logic             ovf_valid_q, ovf_valid_d;
    logic [CW-1:0]    ovf_chan_q, ovf_chan_d;
    logic             chan_ok;

    assign chan_ok = ({1'b0, in_if.in_chan} < CH_LIM);

    // Next-state: beat accounting in RUN, one channel cleared per cycle in SWEEP.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        margin_d    = margin_q;
        ovf_valid_d = 1'b0;
        ovf_chan_d  = ovf_chan_q;
        if (state_q == ST_RUN) begin
            // Out-of-range channels are accepted but leave no trace.
            if (in_if.in_valid && chan_ok) begin
                if (in_if.in_data <= margin_q[in_if.in_chan]) begin
                    count_d[in_if.in_chan]  = count_q[in_if.in_chan] + in_if.in_data;
                    margin_d[in_if.in_chan] = margin_q[in_if.in_chan] - in_if.in_data;
                end else begin
                    ovf_valid_d = 1'b1;
                    ovf_chan_d  = in_if.in_chan;
                    if (MODE == 0) begin
                        count_d[in_if.in_chan]  = '0;
                        margin_d[in_if.in_chan] = MAX_W;
                    end else begin
                        count_d[in_if.in_chan]  = MAX_W;
                        margin_d[in_if.in_chan] = '0;
                    end
                end
            end
            // A beat on the same edge lands first; the sweep clears it later.
            if (clr_all) begin
                state_d = ST_SWEEP;
                idx_d   = '0;
            end
        end else begin
            count_d[idx_q]  = '0;
            margin_d[idx_q] = MAX_W;
            if (idx_q == LAST_CH) begin
                state_d = ST_RUN;
            end
            idx_d = idx_q + CW'(1);
        end
    end

    // State registers with synchronous active-low reset that overrides a sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            ovf_valid_q <= 1'b0;
            ovf_chan_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= '0;
                margin_q[i] <= MAX_W;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ovf_valid_q <= ovf_valid_d;
            ovf_chan_q  <= ovf_chan_d;
            count_q     <= count_d;
            margin_q    <= margin_d;
        end
    end

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_pack
        assign count[g*WIDTH +: WIDTH]  = count_q[g];
        assign margin[g*WIDTH +: WIDTH] = margin_q[g];
        assign hit[g]                   = (count_q[g] == MAX_W);
    end

    assign in_if.in_ready = (state_q == ST_RUN);
    assign sweep_busy     = (state_q == ST_SWEEP);
    assign ovf_valid      = ovf_valid_q;
    assign ovf_chan       = ovf_chan_q;

`ifdef FORMAL
    logic f_prev_accept_q;
    logic f_init_q = 1'b1;

    always_ff @(posedge clk) begin
        f_init_q <= 1'b0;
    end

    // Remember whether the previous edge accepted a beat.
    always_ff @(posedge clk) begin
        f_prev_accept_q <= rst_n && in_if.in_valid && in_if.in_ready;
    end

    // Start from reset; everything after that is unconstrained.
    always_comb begin
        if (f_init_q) assume (!rst_n);
    end

    // Safety properties, valid from the first post-reset cycle.
    always_comb begin
        if (!f_init_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                assert (count_q[i] <= MAX_W);
                assert (({1'b0, count_q[i]} + {1'b0, margin_q[i]}) == {1'b0, MAX_W});
            end
            if (ovf_valid_q) assert (f_prev_accept_q);
            if (sweep_busy) assert (!in_if.in_ready);
        end
    end

    // Reachability of the interesting corners.
    always_comb begin
        cover (count_q[0] == WIDTH'(42));
        cover (hit[0]);
        cover (ovf_valid_q);
        cover (state_q == ST_SWEEP && idx_q == LAST_CH);
    end
`endif

endmodule

// File: tb/tb_budget_accum.sv
// Bench for budget_accum: a MODE 0 instance with 4 channels and a MODE 1
// instance with 3 channels run side by side against a behavioural model.
module tb_budget_accum;

    localparam int MAXC = 111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUTs ----------------
    budget_accum_if #(.WIDTH(8), .CW(2)) if_a ();
    budget_accum_if #(.WIDTH(8), .CW(2)) if_b ();

    logic        clr_a, clr_b;
    logic [31:0] count_a, margin_a;
    logic [3:0]  hit_a;
    logic        ovf_a, busy_a;
    logic [1:0]  ovfc_a;
    logic [23:0] count_b, margin_b;
    logic [2:0]  hit_b;
    logic        ovf_b, busy_b;
    logic [1:0]  ovfc_b;

    budget_accum #(.WIDTH(8), .CHANNELS(4), .MAX_COUNT(MAXC), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_if(if_a), .clr_all(clr_a),
        .count(count_a), .margin(margin_a), .hit(hit_a),
        .ovf_valid(ovf_a), .ovf_chan(ovfc_a), .sweep_busy(busy_a)
    );

    budget_accum #(.WIDTH(8), .CHANNELS(3), .MAX_COUNT(MAXC), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_if(if_b), .clr_all(clr_b),
        .count(count_b), .margin(margin_b), .hit(hit_b),
        .ovf_valid(ovf_b), .ovf_chan(ovfc_b), .sweep_busy(busy_b)
    );

    // ---------------- model ----------------
    int n_ch[2]   = '{4, 3};
    int m_mode[2] = '{0, 1};
    int m_cnt[2][4];
    bit m_sweep[2];
    int m_idx[2];
    bit m_ovf[2];
    int m_ovfc[2];

    task automatic model_edge(input int d, input bit rst, input bit v, input int c,
                              input int dat, input bit clr);
        if (rst) begin
            for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
            m_sweep[d] = 0;
            m_idx[d]   = 0;
            m_ovf[d]   = 0;
            m_ovfc[d]  = 0;
            return;
        end
        m_ovf[d] = 0;
        if (!m_sweep[d]) begin
            if (v && c < n_ch[d]) begin
                if (dat <= MAXC - m_cnt[d][c]) begin
                    m_cnt[d][c] = m_cnt[d][c] + dat;
                end else begin
                    m_ovf[d]    = 1;
                    m_ovfc[d]   = c;
                    m_cnt[d][c] = (m_mode[d] == 0) ? 0 : MAXC;
                end
            end
            if (clr) begin
                m_sweep[d] = 1;
                m_idx[d]   = 0;
            end
        end else begin
            m_cnt[d][m_idx[d]] = 0;
            if (m_idx[d] == n_ch[d] - 1) m_sweep[d] = 0;
            m_idx[d] = m_idx[d] + 1;
        end
    endtask

    // {count[31:0], margin[31:0], hit[3:0], ovf_valid, ovf_chan[1:0], in_ready, sweep_busy}
    function automatic logic [72:0] pack_exp(input int d);
        logic [31:0] c;
        logic [31:0] m;
        logic [3:0]  h;
        c = '0;
        m = '0;
        h = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < n_ch[d]) begin
                c[k*8 +: 8] = 8'(m_cnt[d][k]);
                m[k*8 +: 8] = 8'(MAXC - m_cnt[d][k]);
                h[k]        = (m_cnt[d][k] == MAXC);
            end
        end
        return {c, m, h, m_ovf[d], 2'(m_ovfc[d]), !m_sweep[d], m_sweep[d]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [72:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_dut(input string nm, input logic [72:0] obs, input logic [72:0] exp);
        check({nm, " count"},  obs[72:41], exp[72:41]);
        check({nm, " margin"}, obs[40:9],  exp[40:9]);
        check({nm, " hit"},    32'(obs[8:5]), 32'(exp[8:5]));
        check({nm, " ovf"},    32'(obs[4:2]), 32'(exp[4:2]));
        check({nm, " ctrl"},   32'(obs[1:0]), 32'(exp[1:0]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit va, input int ca, input int da, input bit clra,
                        input bit vb, input int cb, input int db, input bit clrb);
        logic [72:0] obs;
        if_a.in_valid = va;
        if_a.in_chan  = ca[1:0];
        if_a.in_data  = da[7:0];
        clr_a         = clra;
        if_b.in_valid = vb;
        if_b.in_chan  = cb[1:0];
        if_b.in_data  = db[7:0];
        clr_b         = clrb;
        model_edge(0, !rst_n, va, ca, da, clra);
        model_edge(1, !rst_n, vb, cb, db, clrb);
        exp_q.push_back(pack_exp(0));
        exp_q.push_back(pack_exp(1));
        @(posedge clk);
        #1;
        obs = {count_a, margin_a, hit_a, ovf_a, ovfc_a, if_a.in_ready, busy_a};
        compare_dut("a", obs, exp_q.pop_front());
        obs = {8'h00, count_b, 8'h00, margin_b, 1'b0, hit_b, ovf_b, ovfc_b, if_b.in_ready, busy_b};
        compare_dut("b", obs, exp_q.pop_front());
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat_a(input int c, input int d);
        step(1, c, d, 0, 0, 0, 0, 0);
    endtask

    task automatic beat_b(input int c, input int d);
        step(0, 0, 0, 0, 1, c, d, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;

        // accumulation toward 42 on a channel 0
        beat_a(0, 10);
        beat_a(0, 20);
        beat_a(0, 12);
        idle();

        // MODE 0 restart, then exact fill to the budget
        beat_a(1, 100);
        beat_a(1, 12);
        idle();
        beat_a(1, 100);
        beat_a(1, 11);
        idle();

        // MODE 1 saturation, repeated overflow, zero beat at zero margin
        beat_b(0, 100);
        beat_b(0, 50);
        beat_b(0, 1);
        beat_b(0, 0);
        idle();

        // channel outside the configured range is swallowed
        beat_b(3, 7);
        beat_b(2, 9);
        beat_b(3, 200);
        idle();

        // sweep with a coincident beat and an ignored second clear
        beat_a(2, 5);
        beat_a(3, 9);
        step(1, 3, 5, 1, 0, 0, 0, 0);
        idle();
        step(1, 2, 7, 1, 0, 0, 0, 1);
        idle();
        idle();
        idle();
        beat_a(0, 3);
        idle();

        // random traffic with occasional clears on both instances
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 70),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 70),
                 $urandom_range(0, 15) == 0);
        end

        // let any sweep drain, load channels, then reset in sweep cycle 2
        for (int i = 0; i < 5; i++) idle();
        beat_a(0, 30);
        beat_a(2, 40);
        beat_a(3, 50);
        step(0, 0, 0, 1, 0, 0, 0, 1);
        idle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        idle();
        beat_a(3, 4);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/budget_accum.md
# budget_accum

Multi-channel budget accumulator: the parametrised successor of the single-channel count/margin checker used in the formal test suite. Each channel keeps a running sum of accepted data beats against a fixed budget MAX_COUNT. A selectable mode decides the response when a beat would exceed the budget. A sweep FSM clears all channels under valid/ready backpressure, and built-in formal properties make the block directly provable with the flow.

## Interface
- WIDTH, 8: data/count/margin width in bits.
- CHANNELS, 2: number of independent accumulators, at least 1.
- MAX_COUNT, 111: budget per channel; must be less than 2**WIDTH.
- MODE, 0: overflow response. 0 = RESTART, 1 = SATURATE.
- CW, derived: max(1, $clog2(CHANNELS)).

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  data beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- in_chan  in  CW  target channel of the beat.
- in_data  in  WIDTH  beat value.
- clr_all  in  1  single-cycle request to clear every channel.
- count  out  CHANNELS*WIDTH  per-channel accumulated sum; channel i is at bits [i*WIDTH +: WIDTH].
- margin  out  CHANNELS*WIDTH  per-channel remaining budget, same packing.
- hit  out  CHANNELS  hit[i] = (count[i] == MAX_COUNT).
- ovf_valid  out  1  one-cycle pulse: an accepted beat exceeded its margin.
- ovf_chan  out  CW  channel of the last overflow; holds its value between pulses.
- sweep_busy  out  1  clear sweep in progress.

## Operation
- Reset (rst_n low at a posedge) sets:
  - all count = 0 and all margin = MAX_COUNT;
  - ovf_valid = 0 and ovf_chan = 0;
  - FSM to RUN, sweep_busy = 0, in_ready = 1.
- Reset overrides everything, including a sweep in progress.
- Accept: in_valid && in_ready. For channel c = in_chan and value d = in_data:
  - d <= margin[c]: count[c] += d and margin[c] -= d. Equality is legal and gives count[c] == MAX_COUNT.
  - d > margin[c], MODE 0: count[c] = 0, margin[c] = MAX_COUNT, ovf_valid = 1, ovf_chan = c.
  - d > margin[c], MODE 1: count[c] = MAX_COUNT, margin[c] = 0, ovf_valid = 1, ovf_chan = c.
  - in_chan >= CHANNELS: the beat is accepted and dropped. No state changes and no ovf_valid pulse.
- Arithmetic:
  - The comparison is unsigned at WIDTH bits.
  - The add cannot wrap, because d <= margin guarantees count + d <= MAX_COUNT.
  - Invariant count[i] + margin[i] == MAX_COUNT holds at every cycle.
- FSM states are RUN and SWEEP.
  - RUN to SWEEP: clr_all == 1 at a posedge in RUN. The sweep index is set to 0.
  - In SWEEP: each cycle clears channel idx (count = 0, margin = MAX_COUNT), then idx += 1.
  - SWEEP to RUN: on the cycle that clears channel CHANNELS-1.
  - A sweep therefore lasts exactly CHANNELS cycles.
  - clr_all during SWEEP is ignored; it is not queued.
- in_ready = (state == RUN). sweep_busy = (state == SWEEP). Both are driven from state registers only, with no combinational path from inputs.
- clr_all and an accepted beat in the same RUN cycle: the beat is applied at that edge, and the sweep then clears that channel in turn.
- Formal block (`ifdef FORMAL`), which must prove with the depth-20 BMC and the prove task:
  - Properties asserted for every i:
    - count[i] <= MAX_COUNT;
    - count[i] + margin[i] == MAX_COUNT;
    - ovf_valid implies the previous cycle had an accepted beat;
    - !in_ready while sweep_busy.
  - Covers required:
    - count[0] == 42;
    - hit[0];
    - ovf_valid in each MODE;
    - completion of a sweep.
  - The only input constraint is rst_n low in the first cycle.

## Timing
- Accepted beat: count, margin and hit are updated at the accepting edge and visible the next cycle, i.e. 1-cycle latency.
- ovf_valid is asserted in the cycle after the accepting edge, aligned with the updated count, and is high for exactly one cycle per overflowing beat.
- Back-to-back beats to the same channel are allowed every cycle. Each beat sees the margin left by the previous beat; there are no hazards.
- clr_all at edge N:
  - in_ready is low from cycle N+1 through N+CHANNELS;
  - channel k is cleared at edge N+1+k;
  - in_ready returns high at cycle N+CHANNELS+1.
- Reset mid-sweep: at the next cycle the state is RUN, all channels are cleared, and no partial sweep resumes.

## Test plan
- Reset, then beats 10, 20, 12 on channel 0 -> count[0] = 10, 30, 42 on successive cycles; margin[0] = 69; hit = 0; no ovf.
- MODE 0, channel 1 at count 100, margin 11; beat 12 -> count[1] = 0, margin[1] = 111, ovf_valid pulse with ovf_chan = 1. A beat of 11 instead -> count[1] = 111, hit[1] = 1, no ovf.
- MODE 1, channel 0 at count 100; beat 50 -> count[0] = 111, margin[0] = 0, ovf pulse. A further beat of 1 -> count stays at 111 with another ovf pulse; a beat of 0 -> no ovf.
- CHANNELS = 4, all channels nonzero; clr_all pulse together with a valid beat 5 to channel 3 -> the beat is applied, in_ready is low for 4 cycles, channels clear in order 0 through 3, and all counts are 0 when in_ready returns. A second clr_all during the sweep has no effect.
- Beat with in_chan = 3 while CHANNELS = 3 -> accepted (in_ready = 1), no count changes, no ovf.
- Reset asserted during sweep cycle 2 -> next cycle in_ready = 1, sweep_busy = 0, all count = 0, all margin = 111.
